// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Constants shared across the RV32I pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Default datapath and address width
  localparam int D_WIDTH_DEFAULT = 32;

  // addi x0,x0,0 is the canonical bubble placed in pipeline registers
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Boot vector
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Fetch program counter with next-PC select, stall enable and
//               asynchronous reset to the boot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
  import riscv_pkg::*;
#(
  parameter int                 D_WIDTH  = D_WIDTH_DEFAULT,
  parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallF,
  input  logic               PCSrcE,
  input  logic [D_WIDTH-1:0] PCTargetE,
  input  logic [D_WIDTH-1:0] PCPlus4F,
  output logic [D_WIDTH-1:0] PCF
);

  logic [D_WIDTH-1:0] r_pcf;
  logic [D_WIDTH-1:0] w_pc_next;
  logic               w_pc_en;

  // Redirect target is forced word-aligned; a redirect beats the stall so a
  // taken branch resolved during a load-use stall is never dropped.
  assign w_pc_next = PCSrcE ? {PCTargetE[D_WIDTH-1:2], 2'b00} : PCPlus4F;
  assign w_pc_en   = PCSrcE | ~StallF;

  // PC register: reset to boot vector, otherwise advance when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf <= RESET_PC;
    end else if (w_pc_en) begin
      r_pcf <= w_pc_next;
    end
  end

  assign PCF = r_pcf;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch stage. Owns the PC and the IF/ID
//               pipeline register; applies stall, flush and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                 D_WIDTH  = D_WIDTH_DEFAULT,
  parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [D_WIDTH-1:0] PCTargetE,
  input  logic [D_WIDTH-1:0] ImemData,
  output logic [D_WIDTH-1:0] ImemAddr,
  output logic [D_WIDTH-1:0] InstrD,
  output logic [D_WIDTH-1:0] PCD,
  output logic [D_WIDTH-1:0] PCPlus4D,
  output logic               ValidD
);

  localparam logic [D_WIDTH-1:0] c_bubble_instr = D_WIDTH'(NOP_INSTR);

  logic [D_WIDTH-1:0] w_pcf;
  logic [D_WIDTH-1:0] w_pcplus4f;

  logic [D_WIDTH-1:0] r_instr_d;
  logic [D_WIDTH-1:0] r_pc_d;
  logic [D_WIDTH-1:0] r_pcplus4_d;
  logic               r_valid_d;

  // Wraps silently modulo 2^D_WIDTH
  assign w_pcplus4f = w_pcf + D_WIDTH'(4);

  pc_reg #(
    .D_WIDTH  (D_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .PCPlus4F  (w_pcplus4f),
    .PCF       (w_pcf)
  );

  // IF/ID register: flush beats stall, stall beats load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d   <= c_bubble_instr;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (FlushD) begin
      r_instr_d   <= c_bubble_instr;
      r_pc_d      <= '0;
      r_pcplus4_d <= '0;
      r_valid_d   <= 1'b0;
    end else if (!StallD) begin
      r_instr_d   <= ImemData;
      r_pc_d      <= w_pcf;
      r_pcplus4_d <= w_pcplus4f;
      r_valid_d   <= 1'b1;
    end
  end

  assign ImemAddr = w_pcf;
  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pcplus4_d;
  assign ValidD   = r_valid_d;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a behavioural model
//               of the fetch/decode hand-off and a hashed instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_nop   = 32'h00000013;
  localparam logic [31:0] c_boot  = 32'hBFC00000;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, ImemData, ImemAddr, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  logic [31:0] salt;

  // Reference state: what Fetch and Decode should hold
  logic [31:0] m_pcf, m_instr, m_pcd, m_pc4;
  logic        m_valid;

  fetch_stage #(.D_WIDTH(32), .RESET_PC(32'hBFC00000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ImemData  (ImemData),
    .ImemAddr  (ImemAddr),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: address-dependent pseudo-random word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  // Asynchronous instruction memory
  assign ImemData = mem_word(ImemAddr);

  task automatic model_reset();
    m_pcf = c_boot; m_instr = c_nop; m_pcd = 0; m_pc4 = 0; m_valid = 0;
  endtask

  // One clock: apply the fetch rules to the model, then settle past the edge
  task automatic cycle();
    logic [31:0] npc;
    @(posedge clk);
    if (rst_n) begin
      if (PCSrcE)       npc = PCTargetE & 32'hFFFFFFFC;
      else if (!StallF) npc = m_pcf + 32'd4;
      else              npc = m_pcf;
      if (FlushD) begin
        m_instr = c_nop; m_pcd = 0; m_pc4 = 0; m_valid = 0;
      end else if (!StallD) begin
        m_instr = mem_word(m_pcf); m_pcd = m_pcf; m_pc4 = m_pcf + 32'd4; m_valid = 1;
      end
      m_pcf = npc;
    end
    #1;
  endtask

  task automatic idle_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) cycle();
    checks++; if (ImemAddr !== c_boot) begin errors++; $display("FAIL reset_pcf: got %h expected %h", ImemAddr, c_boot); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ValidD); end
    checks++; if (InstrD !== c_nop) begin errors++; $display("FAIL reset_instr: got %h expected %h", InstrD, c_nop); end
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h/%h expected 0/0", PCD, PCPlus4D); end
    rst_n = 1;
    cycle();
    checks++; if (PCD !== c_boot || ValidD !== 1'b1) begin errors++; $display("FAIL first_fetch: got pcd %h valid %b expected %h 1", PCD, ValidD, c_boot); end
    checks++; if (InstrD !== mem_word(c_boot)) begin errors++; $display("FAIL first_instr: got %h expected %h", InstrD, mem_word(c_boot)); end
  endtask

  task automatic test_sequential();
    logic [31:0] prev;
    for (int i = 0; i < 4; i++) begin
      prev = PCD;
      cycle();
      checks++; if (PCD !== prev + 32'd4) begin errors++; $display("FAIL seq_pcd: got %h expected %h", PCD, prev + 32'd4); end
      checks++; if (PCPlus4D !== PCD + 32'd4 || PCPlus4D !== m_pc4) begin errors++; $display("FAIL seq_pc4: got %h expected %h", PCPlus4D, m_pc4); end
      checks++; if (InstrD !== mem_word(prev + 32'd4)) begin errors++; $display("FAIL seq_instr: got %h expected %h", InstrD, mem_word(prev + 32'd4)); end
    end
  endtask

  task automatic test_branch();
    PCSrcE = 1; FlushD = 1; PCTargetE = 32'hBFC00042;
    cycle();
    idle_inputs();
    checks++; if (ImemAddr !== 32'hBFC00040) begin errors++; $display("FAIL br_pcf: got %h expected bfc00040", ImemAddr); end
    checks++; if (ValidD !== 1'b0 || InstrD !== c_nop) begin errors++; $display("FAIL br_bubble: got valid %b instr %h expected 0 %h", ValidD, InstrD, c_nop); end
    cycle();
    checks++; if (PCD !== 32'hBFC00040 || ValidD !== 1'b1) begin errors++; $display("FAIL br_target: got pcd %h valid %b expected bfc00040 1", PCD, ValidD); end
    checks++; if (InstrD !== mem_word(32'hBFC00040)) begin errors++; $display("FAIL br_instr: got %h expected %h", InstrD, mem_word(32'hBFC00040)); end
  endtask

  task automatic test_stall();
    logic [31:0] pcf0, instr0, pcd0;
    pcf0 = ImemAddr; instr0 = InstrD; pcd0 = PCD;
    StallF = 1; StallD = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (ImemAddr !== pcf0 || InstrD !== instr0 || PCD !== pcd0) begin errors++; $display("FAIL stall_hold: got %h/%h/%h expected %h/%h/%h", ImemAddr, InstrD, PCD, pcf0, instr0, pcd0); end
    end
    idle_inputs();
    cycle();
    checks++; if (PCD !== pcd0 + 32'd4) begin errors++; $display("FAIL stall_resume: got %h expected %h", PCD, pcd0 + 32'd4); end
  endtask

  task automatic test_corners();
    logic [31:0] tgt;
    tgt = $urandom;
    StallF = 1; StallD = 1; PCSrcE = 1; PCTargetE = tgt;
    cycle();
    checks++; if (ImemAddr !== (tgt & 32'hFFFFFFFC)) begin errors++; $display("FAIL stall_redirect: got %h expected %h", ImemAddr, tgt & 32'hFFFFFFFC); end
    idle_inputs();
    cycle();
    StallD = 1; FlushD = 1;
    cycle();
    checks++; if (ValidD !== 1'b0 || InstrD !== c_nop || PCD !== 32'h0) begin errors++; $display("FAIL flush_over_stall: got valid %b instr %h pcd %h expected 0 %h 0", ValidD, InstrD, PCD, c_nop); end
    idle_inputs();
    PCSrcE = 1; FlushD = 1; PCTargetE = 32'hFFFFFFFC;
    cycle();
    idle_inputs();
    checks++; if (ImemAddr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_target: got %h expected fffffffc", ImemAddr); end
    cycle();
    checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL wrap_pcf: got %h expected 00000000", ImemAddr); end
    checks++; if (PCD !== 32'hFFFFFFFC || PCPlus4D !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h/%h expected fffffffc/00000000", PCD, PCPlus4D); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = StallF ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      PCSrcE    = ($urandom_range(0, 7) == 0);
      FlushD    = PCSrcE | ($urandom_range(0, 9) == 0);
      PCTargetE = $urandom;
      cycle();
      checks++;
      if (ImemAddr !== m_pcf || InstrD !== m_instr || PCD !== m_pcd || PCPlus4D !== m_pc4 || ValidD !== m_valid) begin
        errors++;
        $display("FAIL rand_%0d: got pcf %h instr %h pcd %h pc4 %h v %b expected %h %h %h %h %b",
                 i, ImemAddr, InstrD, PCD, PCPlus4D, ValidD, m_pcf, m_instr, m_pcd, m_pc4, m_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    cycle();
    StallF = 1; StallD = 1;
    cycle();
    #2;
    rst_n = 0;
    #1;
    checks++; if (ImemAddr !== c_boot) begin errors++; $display("FAIL async_pcf: got %h expected %h", ImemAddr, c_boot); end
    checks++; if (ValidD !== 1'b0 || InstrD !== c_nop || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL async_ifid: got v %b instr %h pcd %h pc4 %h expected 0 %h 0 0", ValidD, InstrD, PCD, PCPlus4D, c_nop); end
    model_reset();
    cycle();
    idle_inputs();
    rst_n = 1;
    cycle();
    checks++; if (PCD !== c_boot || ValidD !== 1'b1 || ImemAddr !== c_boot + 32'd4) begin errors++; $display("FAIL async_resume: got pcd %h v %b pcf %h expected %h 1 %h", PCD, ValidD, ImemAddr, c_boot, c_boot + 32'd4); end
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_corners();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
